// File: rtl/control_multicycle.sv
// Multicycle control unit for an accumulator CPU.
// It owns the PC, the IR and a return-address stack, and decodes each instruction into datapath strobes.
module control_multicycle #(
  parameter int unsigned OPERAND_WIDTH     = 11,
  parameter int unsigned OPCODE_WIDTH      = 5,
  parameter int unsigned INSTRUCTION_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH,
  parameter int unsigned STACK_DEPTH       = 4
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic                         instr_valid_in,
  output logic                         instr_req_out,
  output logic [OPERAND_WIDTH-1:0]     pc_out,
  input  logic                         status_Z_in,
  input  logic                         status_N_in,
  output logic [OPERAND_WIDTH-1:0]     address_out,
  output logic [OPERAND_WIDTH-1:0]     operand_out,
  output logic [1:0]                   sel_A_out,
  output logic                         sel_B_out,
  output logic                         alu_op_out,
  output logic                         data_memory_wr_out,
  output logic                         acc_wr_out,
  output logic                         status_wr_out,
  output logic                         acc_reset_out,
  output logic                         status_reset_out,
  output logic                         halted_out,
  output logic                         error_out,
  output logic                         illegal_out
);

  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OpHlt  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OpSto  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OpLd   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OpLdi  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OpAdd  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OpAddi = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OpSub  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OpSubi = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OpBne  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OpBgt  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OpBge  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OpBlt  = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OpBle  = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OpJmp  = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OpCall = OPCODE_WIDTH'(15);
  localparam logic [OPCODE_WIDTH-1:0] OpRet  = OPCODE_WIDTH'(16);

  typedef enum logic [1:0] {StInit, StFetch, StExec, StHalt} state_e;

  state_e                           state_q, state_d;
  logic [OPERAND_WIDTH-1:0]         pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]     ir_q, ir_d;
  logic [SpW-1:0]                   sp_q, sp_d;
  logic [OPERAND_WIDTH-1:0]         stack_q [STACK_DEPTH];
  logic [OPERAND_WIDTH-1:0]         stack_d [STACK_DEPTH];
  logic                             error_q, error_d;

  logic [OPCODE_WIDTH-1:0]          opcode;
  logic [OPERAND_WIDTH-1:0]         operand;
  logic [OPERAND_WIDTH-1:0]         pc_inc;
  logic [IdxW-1:0]                  push_idx, pop_idx;

  assign opcode   = ir_q[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign operand  = ir_q[OPERAND_WIDTH-1:0];
  assign pc_inc   = pc_q + OPERAND_WIDTH'(1);
  assign push_idx = IdxW'(sp_q);
  assign pop_idx  = IdxW'(sp_q - SpW'(1));

  assign pc_out      = pc_q;
  assign address_out = operand;
  assign operand_out = operand;
  assign halted_out  = (state_q == StHalt);
  assign error_out   = error_q;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    ir_d               = ir_q;
    sp_d               = sp_q;
    stack_d            = stack_q;
    error_d            = error_q;
    instr_req_out      = 1'b0;
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    data_memory_wr_out = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    acc_reset_out      = 1'b0;
    status_reset_out   = 1'b0;
    illegal_out        = 1'b0;

    case (state_q)
      StInit: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
        state_d          = StFetch;
      end
      StFetch: begin
        instr_req_out = 1'b1;
        if (instr_valid_in) begin
          ir_d    = instruction_in;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        case (opcode)
          OpHlt: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          OpSto: data_memory_wr_out = 1'b1;
          OpLd:  acc_wr_out = 1'b1;
          OpLdi: begin
            acc_wr_out = 1'b1;
            sel_A_out  = 2'b01;
          end
          OpAdd, OpAddi, OpSub, OpSubi: begin
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
            sel_A_out     = 2'b10;
            sel_B_out     = (opcode == OpAddi) || (opcode == OpSubi);
            alu_op_out    = (opcode == OpSub) || (opcode == OpSubi);
          end
          OpBeq: if (status_Z_in) pc_d = operand;
          OpBne: if (!status_Z_in) pc_d = operand;
          OpBgt: if (!status_Z_in && !status_N_in) pc_d = operand;
          OpBge: if (!status_N_in) pc_d = operand;
          OpBlt: if (status_N_in) pc_d = operand;
          OpBle: if (status_Z_in || status_N_in) pc_d = operand;
          OpJmp: pc_d = operand;
          OpCall: begin
            if (sp_q == SpW'(STACK_DEPTH)) begin
              pc_d    = pc_q;
              error_d = 1'b1;
              state_d = StHalt;
            end else begin
              stack_d[push_idx] = pc_inc;
              sp_d              = sp_q + SpW'(1);
              pc_d              = operand;
            end
          end
          OpRet: begin
            if (sp_q == '0) begin
              pc_d    = pc_q;
              error_d = 1'b1;
              state_d = StHalt;
            end else begin
              sp_d = sp_q - SpW'(1);
              pc_d = stack_q[pop_idx];
            end
          end
          default: illegal_out = 1'b1;
        endcase
      end
      StHalt: ;
      default: state_d = StInit;
    endcase

    // A reset arriving during EXECUTE must not let any write strobe escape.
    if (reset_in) begin
      data_memory_wr_out = 1'b0;
      acc_wr_out         = 1'b0;
      status_wr_out      = 1'b0;
      illegal_out        = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= StInit;
      pc_q    <= '0;
      ir_q    <= '0;
      sp_q    <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      error_q <= error_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_control_multicycle.sv
// Self-checking bench for control_multicycle: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_control_multicycle;

  localparam int OW    = 11;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic [IW-1:0] instruction_in = '0;
  logic          instr_valid_in = 1'b0;
  logic          status_z = 1'b0;
  logic          status_n = 1'b0;
  logic          instr_req_out;
  logic [OW-1:0] pc_out, address_out, operand_out;
  logic [1:0]    sel_a;
  logic          sel_b, alu_op, dm_wr, acc_wr, status_wr, acc_reset, status_reset;
  logic          halted_out, error_out, illegal_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [OW-1:0] model_pc;
  logic [OW-1:0] model_stack[$];

  always #5 clk = ~clk;

  control_multicycle #(
    .OPERAND_WIDTH(OW),
    .OPCODE_WIDTH(5),
    .INSTRUCTION_WIDTH(IW),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clock_in(clk),
    .reset_in(reset_in),
    .instruction_in(instruction_in),
    .instr_valid_in(instr_valid_in),
    .instr_req_out(instr_req_out),
    .pc_out(pc_out),
    .status_Z_in(status_z),
    .status_N_in(status_n),
    .address_out(address_out),
    .operand_out(operand_out),
    .sel_A_out(sel_a),
    .sel_B_out(sel_b),
    .alu_op_out(alu_op),
    .data_memory_wr_out(dm_wr),
    .acc_wr_out(acc_wr),
    .status_wr_out(status_wr),
    .acc_reset_out(acc_reset),
    .status_reset_out(status_reset),
    .halted_out(halted_out),
    .error_out(error_out),
    .illegal_out(illegal_out)
  );

  logic [7:0] ctl_act;
  assign ctl_act = {sel_a, sel_b, alu_op, dm_wr, acc_wr, status_wr, illegal_out};

  // Expected {sel_A, sel_B, alu_op, dm_wr, acc_wr, status_wr, illegal} in EXECUTE.
  function automatic logic [7:0] exp_ctl(input int opc);
    logic [1:0] a = 2'b00;
    logic b = 0, op = 0, dm = 0, aw = 0, sw = 0, il = 0;
    if (opc == 1) dm = 1;
    if (opc == 2) aw = 1;
    if (opc == 3) begin aw = 1; a = 2'b01; end
    if (opc >= 4 && opc <= 7) begin
      aw = 1; sw = 1; a = 2'b10;
      b  = (opc == 5) || (opc == 7);
      op = (opc >= 6);
    end
    if (opc >= 17) il = 1;
    return {a, b, op, dm, aw, sw, il};
  endfunction

  function automatic bit exp_taken(input int opc, input bit z, input bit n);
    case (opc)
      8:  return z;
      9:  return !z;
      10: return !z && !n;
      11: return !n;
      12: return n;
      13: return z || n;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_in       = 1'b1;
    instr_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_in = 1'b0;
    model_pc = '0;
    model_stack.delete();
  endtask

  // Waits for a fetch request, optionally stalls, then presents one instruction.
  // Returns at the falling edge inside the EXECUTE cycle.
  task automatic issue(input logic [IW-1:0] instr, input bit z, input bit n, input int stall);
    int guard = 0;
    while (!instr_req_out && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!instr_req_out) begin
      n_fail++;
      $display("FAIL fetch_timeout: instr_req_out=%b after %0d cycles, want 1", instr_req_out, guard);
    end
    repeat (stall) begin
      instr_valid_in = 1'b0;
      instruction_in = IW'($urandom);
      @(negedge clk);
    end
    instruction_in = instr;
    instr_valid_in = 1'b1;
    status_z       = z;
    status_n       = n;
    @(negedge clk);
    instr_valid_in = 1'b0;
    instruction_in = IW'($urandom);
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({instr_req_out, dm_wr, acc_wr, status_wr, illegal_out, pc_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_quiet: req/strobes/pc=%b/%b%b%b%b/%h want all 0",
               instr_req_out, dm_wr, acc_wr, status_wr, illegal_out, pc_out);
    end
    n_cmp++;
    if ({halted_out, error_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: halted/error=%b%b want 00", halted_out, error_out);
    end
    reset_in = 1'b0;
    n_cmp++;
    if ({acc_reset, status_reset, instr_req_out} !== 3'b110) begin
      n_fail++;
      $display("FAIL init_clear: acc_rst/st_rst/req=%b%b%b want 110",
               acc_reset, status_reset, instr_req_out);
    end
    step();
    n_cmp++;
    if ({acc_reset, status_reset, instr_req_out, pc_out} !== {3'b001, 11'd0}) begin
      n_fail++;
      $display("FAIL first_fetch: acc_rst/st_rst/req=%b%b%b pc=%h want 001 pc=000",
               acc_reset, status_reset, instr_req_out, pc_out);
    end
    model_pc = '0;
    model_stack.delete();
  endtask

  task automatic test_ldi_add();
    do_reset();
    issue(16'h1805, 0, 0, 0);
    n_cmp++;
    if (ctl_act !== exp_ctl(3) || operand_out !== 11'd5 || address_out !== 11'd5) begin
      n_fail++;
      $display("FAIL ldi_decode: ctl=%b opnd=%h addr=%h want ctl=%b opnd=005 addr=005",
               ctl_act, operand_out, address_out, exp_ctl(3));
    end
    step();
    issue(16'h2003, 0, 0, 0);
    n_cmp++;
    if (ctl_act !== exp_ctl(4)) begin
      n_fail++;
      $display("FAIL add_decode: ctl=%b want %b", ctl_act, exp_ctl(4));
    end
    step();
    n_cmp++;
    if (pc_out !== 11'd2) begin
      n_fail++;
      $display("FAIL add_pc: pc=%h want 002", pc_out);
    end
  endtask

  task automatic test_branches();
    logic [OW-1:0] opnd;
    logic [OW-1:0] want;
    int opc;
    bit z, n;
    do_reset();
    issue(16'h4003, 1, 0, 0); step();
    n_cmp++;
    if (pc_out !== 11'h003) begin n_fail++; $display("FAIL beq_taken: pc=%h want 003", pc_out); end
    issue(16'h4003, 0, 0, 0); step();
    n_cmp++;
    if (pc_out !== 11'h004) begin n_fail++; $display("FAIL beq_not: pc=%h want 004", pc_out); end
    issue(16'h6855, 0, 1, 0); step();
    n_cmp++;
    if (pc_out !== 11'h055) begin n_fail++; $display("FAIL ble_taken: pc=%h want 055", pc_out); end
    issue(16'h5123, 1, 0, 0); step();
    n_cmp++;
    if (pc_out !== 11'h056) begin n_fail++; $display("FAIL bgt_not: pc=%h want 056", pc_out); end
    model_pc = 11'h056;
    for (int i = 0; i < 40; i++) begin
      opc  = $urandom_range(8, 14);
      opnd = OW'($urandom);
      z    = 1'($urandom);
      n    = 1'($urandom);
      want = exp_taken(opc, z, n) ? opnd : model_pc + 1'b1;
      issue({5'(opc), opnd}, z, n, $urandom_range(0, 2));
      n_cmp++;
      if (ctl_act !== 8'd0) begin
        n_fail++;
        $display("FAIL branch_ctl: op=%0d ctl=%b want 0", opc, ctl_act);
      end
      step();
      n_cmp++;
      if (pc_out !== want) begin
        n_fail++;
        $display("FAIL branch_pc: op=%0d z=%b n=%b pc=%h want %h", opc, z, n, pc_out, want);
      end
      model_pc = want;
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    issue(16'h7007, 0, 0, 0); step();
    issue(16'h7900, 0, 0, 0); step();
    n_cmp++;
    if (pc_out !== 11'h100) begin n_fail++; $display("FAIL call_pc: pc=%h want 100", pc_out); end
    issue(16'h8000, 0, 0, 0); step();
    n_cmp++;
    if (pc_out !== 11'h008 || error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_pc: pc=%h err=%b want 008 err=0", pc_out, error_out);
    end
  endtask

  task automatic test_overflow();
    logic [OW-1:0] opnd;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      opnd = OW'($urandom);
      issue({5'd15, opnd}, 0, 0, 0);
      step();
      n_cmp++;
      if (i < DEPTH) begin
        if (pc_out !== opnd || {error_out, halted_out} !== 2'b00) begin
          n_fail++;
          $display("FAIL call_nest%0d: pc=%h err/halt=%b%b want %h 00",
                   i, pc_out, error_out, halted_out, opnd);
        end
      end else if ({error_out, halted_out} !== 2'b11) begin
        n_fail++;
        $display("FAIL call_overflow: err/halt=%b%b want 11", error_out, halted_out);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(16'h8000, 0, 0, 0); step();
    repeat (3) step();
    n_cmp++;
    if ({error_out, halted_out, instr_req_out} !== 3'b110) begin
      n_fail++;
      $display("FAIL ret_underflow: err/halt/req=%b%b%b want 110",
               error_out, halted_out, instr_req_out);
    end
    do_reset();
    n_cmp++;
    if ({error_out, halted_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL error_clear: err/halt=%b%b want 00", error_out, halted_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      instr_valid_in = 1'b0;
      instruction_in = IW'($urandom);
      n_cmp++;
      if (instr_req_out !== 1'b1 || ctl_act !== 8'd0 || pc_out !== 11'd0 || acc_reset !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: req=%b ctl=%b pc=%h want 1 0 000", i, instr_req_out, ctl_act, pc_out);
      end
      step();
    end
    issue(16'h1801, 0, 0, 0);
    n_cmp++;
    if (ctl_act !== exp_ctl(3)) begin
      n_fail++;
      $display("FAIL stall_resume: ctl=%b want %b", ctl_act, exp_ctl(3));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    issue(16'h77FF, 0, 0, 0); step();
    issue(16'h1801, 0, 0, 0); step();
    n_cmp++;
    if (pc_out !== 11'd0) begin n_fail++; $display("FAIL pc_wrap: pc=%h want 000", pc_out); end
  endtask

  task automatic test_illegal();
    int opc;
    logic [OW-1:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      opc  = $urandom_range(17, 31);
      want = model_pc + 1'b1;
      issue({5'(opc), OW'($urandom)}, 0, 0, 0);
      n_cmp++;
      if (ctl_act !== exp_ctl(opc)) begin
        n_fail++;
        $display("FAIL illegal_pulse: op=%0d ctl=%b want %b", opc, ctl_act, exp_ctl(opc));
      end
      step();
      n_cmp++;
      if (illegal_out !== 1'b0 || pc_out !== want) begin
        n_fail++;
        $display("FAIL illegal_after: op=%0d ill=%b pc=%h want 0 %h", opc, illegal_out, pc_out, want);
      end
      model_pc = want;
    end
  endtask

  task automatic test_halt();
    do_reset();
    issue(16'h702A, 0, 0, 0); step();
    issue(16'h0000, 0, 0, 0);
    n_cmp++;
    if (ctl_act !== 8'd0) begin n_fail++; $display("FAIL hlt_ctl: ctl=%b want 0", ctl_act); end
    step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({halted_out, instr_req_out} !== 2'b10 || pc_out !== 11'h02A || ctl_act !== 8'd0) begin
        n_fail++;
        $display("FAIL halt_hold%0d: halt/req=%b%b pc=%h ctl=%b want 10 02a 0",
                 i, halted_out, instr_req_out, pc_out, ctl_act);
      end
      instr_valid_in = 1'b1;
      instruction_in = 16'h1801;
      step();
    end
    instr_valid_in = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    issue(16'h7033, 0, 0, 0); step();
    issue(16'h2003, 0, 0, 0);
    reset_in = 1'b1;
    #1;
    n_cmp++;
    if ({dm_wr, acc_wr, status_wr, illegal_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_exec_strobe: dm/acc/st/ill=%b%b%b%b want 0000",
               dm_wr, acc_wr, status_wr, illegal_out);
    end
    step();
    n_cmp++;
    if (pc_out !== 11'd0 || instr_req_out !== 1'b0 || acc_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_exec_state: pc=%h req=%b acc_rst=%b want 000 0 1",
               pc_out, instr_req_out, acc_reset);
    end
    reset_in = 1'b0;
    step();
    n_cmp++;
    if (instr_req_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_exec_refetch: req=%b want 1", instr_req_out);
    end
  endtask

  task automatic test_random();
    int opc;
    logic [OW-1:0] opnd;
    logic [OW-1:0] want;
    bit z, n;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      opc = $urandom_range(1, 31);
      if (opc == 15 && model_stack.size() == DEPTH) opc = 3;
      if (opc == 16 && model_stack.size() == 0) opc = 2;
      opnd = OW'($urandom);
      z    = 1'($urandom);
      n    = 1'($urandom);
      issue({5'(opc), opnd}, z, n, $urandom_range(0, 2));
      n_cmp++;
      if (ctl_act !== exp_ctl(opc) || operand_out !== opnd) begin
        n_fail++;
        $display("FAIL rand_ctl: op=%0d ctl=%b opnd=%h want %b %h",
                 opc, ctl_act, operand_out, exp_ctl(opc), opnd);
      end
      if (opc == 15) begin
        model_stack.push_back(model_pc + 1'b1);
        want = opnd;
      end else if (opc == 16) begin
        want = model_stack.pop_back();
      end else begin
        want = exp_taken(opc, z, n) ? opnd : model_pc + 1'b1;
      end
      step();
      n_cmp++;
      if (pc_out !== want || {halted_out, error_out} !== 2'b00) begin
        n_fail++;
        $display("FAIL rand_pc: op=%0d pc=%h halt/err=%b%b want %h 00",
                 opc, pc_out, halted_out, error_out, want);
      end
      model_pc = want;
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_branches();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall();
    test_wrap();
    test_illegal();
    test_halt();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
